avg_collector: RTL and testbench

Receiving end of the averager's result stream. Captures the `valid`/`out` burst produced by the pairwise averager (120 rounded 8-bit averages, one per cycle, contiguous) into an internal buffer. Flags protocol violations (gaps, overflow) and lets a host read the results back one byte per request. It sits directly downstream of the averager in the same clock domain.

---
 rtl/avg_pkg.sv | 13 +
 rtl/avg_buf_ram.sv | 30 +++
 rtl/avg_collector.sv | 121 ++++++++++++
 tb/tb_avg_collector.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/avg_pkg.sv
// Shared constants and state type for the averager result collector.
package avg_pkg;

   localparam int DEPTH_DEFAULT = 120;
   localparam int BUF_SIZE      = 128;
   localparam int PTR_W         = 7;

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_t;

endpackage

// File: rtl/avg_buf_ram.sv
// 128x8 sample buffer: one write port, one synchronous read port with registered output.
module avg_buf_ram
   import avg_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [7:0]       wdata,
   input  logic             re,
   input  logic [PTR_W-1:0] raddr,
   output logic [7:0]       rdata
);

   logic [7:0] mem [BUF_SIZE];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // Output register only moves on a read, so it holds the last byte between reads.
   always_ff @(posedge clk) begin
      if (reset)
         rdata <= '0;
      else if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/avg_collector.sv
// Captures one contiguous burst of DEPTH averager results, flags gaps/overflow, serves readback.
// Optional checksum accumulator enabled by defining AVG_COLLECT_CHECKSUM_EN.
module avg_collector
   import avg_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [7:0]  avg_in,
   input  logic        rd_req,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        done,
   output logic [6:0]  count,
   output logic        gap_err,
   output logic        ovf_err,
   output logic [15:0] checksum
);

   state_t           state;
   state_t           state_next;
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W:0]   cnt;
   logic             wr_en;
   logic             rd_en;
   logic             last_write;

   assign wr_en      = (state == COLLECT) && valid_in;
   assign rd_en      = (state == FULL) && rd_req;
   assign last_write = wr_en && (cnt == (PTR_W+1)'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (reset)
         state <= COLLECT;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         COLLECT: if (last_write) state_next = FULL;
         FULL:    state_next = FULL;
         default: state_next = COLLECT;
      endcase
   end

   // The counter carries one extra bit so DEPTH=128 is reachable; the port clamps at 127.
   always_comb begin
      done  = (state == FULL);
      count = cnt[PTR_W] ? 7'h7F : cnt[PTR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         cnt  <= '0;
      end else if (wr_en) begin
         wptr <= wptr + 1'b1;
         cnt  <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         rptr <= '0;
      else if (rd_en)
         rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         rd_valid <= 1'b0;
      else
         rd_valid <= rd_en;
   end

   // A gap is only meaningful once the burst has started.
   always_ff @(posedge clk) begin
      if (reset) begin
         gap_err <= 1'b0;
         ovf_err <= 1'b0;
      end else begin
         if ((state == COLLECT) && !valid_in && (cnt != '0))
            gap_err <= 1'b1;
         if ((state == FULL) && valid_in)
            ovf_err <= 1'b1;
      end
   end

`ifdef AVG_COLLECT_CHECKSUM_EN
   logic [15:0] sum;

   always_ff @(posedge clk) begin
      if (reset)
         sum <= '0;
      else if (wr_en)
         sum <= sum + {8'h00, avg_in};
   end

   assign checksum = sum;
`else
   assign checksum = '0;
`endif

   avg_buf_ram u_buf (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en),
      .waddr (wptr),
      .wdata (avg_in),
      .re    (rd_en),
      .raddr (rptr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_avg_collector.sv
// Directed bench for avg_collector with a readback scoreboard and a small capture model.
module tb_avg_collector;

   localparam int DEPTH = 120;

   logic        clk;
   logic        reset;
   logic        valid_in;
   logic [7:0]  avg_in;
   logic        rd_req;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        done;
   logic [6:0]  count;
   logic        gap_err;
   logic        ovf_err;
   logic [15:0] checksum;

   int          checks;
   int          errors;

   logic [7:0]  sb [$];
   logic [7:0]  m_mem [128];
   int          m_count;
   int          m_rptr;
   bit          m_full;

   avg_collector #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .valid_in (valid_in),
      .avg_in   (avg_in),
      .rd_req   (rd_req),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .done     (done),
      .count    (count),
      .gap_err  (gap_err),
      .ovf_err  (ovf_err),
      .checksum (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] expSum(input logic [15:0] v);
`ifdef AVG_COLLECT_CHECKSUM_EN
      return v;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock edge, then settle and retire any read that was due this cycle.
   task automatic tick();
      logic [7:0] exp_d;
      logic       exp_v;
      @(posedge clk);
      #1;
      exp_v = (sb.size() != 0);
      checkOutput("rd_valid", 16'(rd_valid), 16'(exp_v));
      if (sb.size() != 0) begin
         exp_d = sb.pop_front();
         if (rd_valid)
            checkOutput("rd_data", 16'(rd_data), 16'(exp_d));
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
      valid_in = v;
      avg_in   = d;
      rd_req   = r;
      if (r && m_full) begin
         sb.push_back(m_mem[m_rptr]);
         m_rptr = (m_rptr == DEPTH - 1) ? 0 : m_rptr + 1;
      end
      if (v && !m_full) begin
         m_mem[m_count] = d;
         m_count++;
         if (m_count == DEPTH)
            m_full = 1'b1;
      end
      tick();
   endtask

   task automatic doReset();
      reset    = 1'b1;
      valid_in = 1'b0;
      avg_in   = 8'h00;
      rd_req   = 1'b0;
      sb.delete();
      m_count  = 0;
      m_rptr   = 0;
      m_full   = 1'b0;
      tick();
      reset = 1'b0;
      checkOutput("reset_rd_data",  16'(rd_data),  16'h0);
      checkOutput("reset_done",     16'(done),     16'h0);
      checkOutput("reset_count",    16'(count),    16'h0);
      checkOutput("reset_gap_err",  16'(gap_err),  16'h0);
      checkOutput("reset_ovf_err",  16'(ovf_err),  16'h0);
      checkOutput("reset_checksum", checksum,      16'h0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      valid_in = 1'b0;
      avg_in   = 8'h00;
      rd_req   = 1'b0;

      doReset();

      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("idle_no_gap", 16'(gap_err), 16'h0);

      // Nominal burst with rd_req held throughout collection, including the final write.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 8'(4 + i), 1'b1);
         if (i == DEPTH - 2) begin
            checkOutput("done_before_last", 16'(done),  16'h0);
            checkOutput("count_before_last", 16'(count), 16'(DEPTH - 1));
         end
      end
      checkOutput("nominal_done",     16'(done),    16'h1);
      checkOutput("nominal_count",    16'(count),   16'(DEPTH));
      checkOutput("nominal_gap_err",  16'(gap_err), 16'h0);
      checkOutput("nominal_ovf_err",  16'(ovf_err), 16'h0);
      checkOutput("nominal_checksum", checksum,     expSum(16'h1DC4));

      // Readout with wrap: 122 back-to-back reads.
      for (int i = 0; i < DEPTH + 2; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         if (i == 0)
            checkOutput("first_read_data", 16'(rd_data), 16'h4);
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("rd_data_hold", 16'(rd_data), 16'h5);
      checkOutput("readout_count", 16'(count), 16'(DEPTH));

      // Gap burst: 50 samples, one idle cycle, 70 samples.
      doReset();
      for (int i = 0; i < 50; i++)
         applyStimulus(1'b1, 8'(4 + i), 1'b0);
      checkOutput("pre_gap_clear", 16'(gap_err), 16'h0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("gap_set", 16'(gap_err), 16'h1);
      for (int i = 50; i < DEPTH; i++)
         applyStimulus(1'b1, 8'(4 + i), 1'b0);
      checkOutput("gap_sticky", 16'(gap_err), 16'h1);
      checkOutput("gap_done",   16'(done),    16'h1);
      checkOutput("gap_count",  16'(count),   16'(DEPTH));

      // Overflow sample coinciding with a read.
      applyStimulus(1'b1, 8'hFF, 1'b1);
      checkOutput("ovf_set",      16'(ovf_err), 16'h1);
      checkOutput("ovf_rd_data",  16'(rd_data), 16'h4);
      checkOutput("ovf_count",    16'(count),   16'(DEPTH));
      checkOutput("ovf_checksum", checksum,     expSum(16'h1DC4));
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("ovf_sticky", 16'(ovf_err), 16'h1);

      // Reset in the middle of a burst, then a fresh constant burst.
      doReset();
      for (int i = 0; i < 60; i++)
         applyStimulus(1'b1, 8'(4 + i), 1'b0);
      checkOutput("mid_count", 16'(count), 16'd60);
      doReset();
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b1, 8'h10, 1'b0);
      checkOutput("fresh_done",     16'(done),  16'h1);
      checkOutput("fresh_count",    16'(count), 16'(DEPTH));
      checkOutput("fresh_checksum", checksum,   expSum(16'h0780));
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("fresh_rd_data", 16'(rd_data), 16'h10);
      checkOutput("fresh_no_err",  16'(gap_err | ovf_err), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
